// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined core: PC arithmetic constants,
// the default bubble instruction and the IF/ID register record.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP           = 32'd4;
    localparam logic [31:0] PC_R15_OFFSET     = 32'd8;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc8;
    } if_id_t;

    // Instruction addresses are always word aligned; low bits are discarded.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_decode_reg.sv
// IF/ID pipeline register. A bubble clears the valid flag and replaces the
// instruction with the NOP word while leaving the R15 value untouched; hold
// freezes the whole record; otherwise the incoming record is captured.
module fetch_decode_reg
    import pipe_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   bubble,
    input  logic   hold,
    input  if_id_t d,
    output if_id_t q
);

    // Register update: reset, then bubble (wins over hold), then hold, then load.
    always_ff @(posedge clk) begin
        if (rst) begin
            q.valid <= 1'b0;
            q.instr <= NOP_INSTR;
            q.pc8   <= '0;
        end else if (bubble) begin
            q.valid <= 1'b0;
            q.instr <= NOP_INSTR;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, tracks the single request in
// flight to the 1-cycle-latency instruction ROM, and feeds the IF/ID register
// that supplies decode. A taken branch costs two bubbles; a stall re-reads
// the pending word from the ROM so no skid buffer is needed.
module fetch_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_F,
    input  logic        flush_D,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic        valid_D,
    output logic [31:0] fetch_count
);

    logic [31:0] fetch_pc;
    logic [31:0] resp_pc;
    logic        resp_valid;

    if_id_t      if_id_d;
    if_id_t      if_id_q;
    logic        if_id_bubble;
    logic        if_id_hold;
    logic        load_valid;

    // A redirect always goes through; otherwise a stall freezes everything.
    assign if_id_bubble = branch_taken | (stall_F & flush_D);
    assign if_id_hold   = stall_F & ~branch_taken;

    // Record offered to IF/ID: the word returning from the ROM this cycle.
    assign if_id_d.valid = resp_valid & ~flush_D;
    assign if_id_d.instr = (resp_valid & ~flush_D) ? imem_rdata : NOP_INSTR;
    assign if_id_d.pc8   = resp_pc + PC_R15_OFFSET;

    // Only a normal (non-stalled, non-redirected) edge can load a live word.
    assign load_valid = ~branch_taken & ~stall_F & if_id_d.valid;

    // ROM address: while stalled, present the pending address again so that
    // imem_rdata keeps carrying the held word through the stall.
    always_comb begin
        imem_addr = fetch_pc;
        if (rst) begin
            imem_addr = RESET_PC;
        end else if (stall_F && !branch_taken) begin
            imem_addr = resp_pc;
        end
    end

    // Fetch PC and in-flight request tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            resp_pc    <= RESET_PC;
            resp_valid <= 1'b0;
        end else if (branch_taken) begin
            fetch_pc   <= word_align(branch_target);
            resp_valid <= 1'b0;
        end else if (!stall_F) begin
            resp_pc    <= fetch_pc;
            resp_valid <= 1'b1;
            fetch_pc   <= fetch_pc + PC_STEP;
        end
    end

    // Count of live instructions handed to decode; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= '0;
        end else if (load_valid) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    fetch_decode_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk    (clk),
        .rst    (rst),
        .bubble (if_id_bubble),
        .hold   (if_id_hold),
        .d      (if_id_d),
        .q      (if_id_q)
    );

    assign instr_D = if_id_q.instr;
    assign pc_D    = if_id_q.pc8;
    assign valid_D = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table for the documented scenarios,
// then randomized control stimulus against a behavioural reference model.
// Two instances run side by side: RESET_PC = 0 and RESET_PC = 0xFFFF_FFF8.
module tb_fetch_stage;

    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] RPC0 = 32'h0000_0000;
    localparam logic [31:0] RPC1 = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        stall_F;
    logic        flush_D;
    logic        branch_taken;
    logic [31:0] branch_target;

    logic [31:0] addr0, rdata0, instr0, pc0, cnt0;
    logic        valid0;
    logic [31:0] addr1, rdata1, instr1, pc1, cnt1;
    logic        valid1;

    int vectors     = 0;
    int miscompares = 0;

    // ROM contents: a bijective scramble of the address, so every word differs.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return ((a ^ 32'h5A5A_0000) * 32'h9E37_79B1) + 32'h1357_9BDF;
    endfunction

    always @(posedge clk) rdata0 <= rom_word(addr0);
    always @(posedge clk) rdata1 <= rom_word(addr1);

    fetch_stage #(.RESET_PC(RPC0), .NOP_INSTR(NOP)) dut (
        .clk (clk), .rst (rst), .stall_F (stall_F), .flush_D (flush_D),
        .branch_taken (branch_taken), .branch_target (branch_target),
        .imem_addr (addr0), .imem_rdata (rdata0), .instr_D (instr0),
        .pc_D (pc0), .valid_D (valid0), .fetch_count (cnt0)
    );

    fetch_stage #(.RESET_PC(RPC1), .NOP_INSTR(NOP)) dut_w (
        .clk (clk), .rst (rst), .stall_F (stall_F), .flush_D (flush_D),
        .branch_taken (branch_taken), .branch_target (branch_target),
        .imem_addr (addr1), .imem_rdata (rdata1), .instr_D (instr1),
        .pc_D (pc1), .valid_D (valid1), .fetch_count (cnt1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst, stall, flush, br;
        logic [31:0] tgt;
        bit          chk;
        bit          v;
        logic [31:0] ins, pc, cnt;
        bit          wchk;
        bit          wv;
        logic [31:0] wins, wpc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, s, f, b, input logic [31:0] t, input bit c,
                       input bit v, input logic [31:0] ins, pc, cnt);
        vec_t e;
        e.rst = r; e.stall = s; e.flush = f; e.br = b; e.tgt = t;
        e.chk = c; e.v = v; e.ins = ins; e.pc = pc; e.cnt = cnt;
        e.wchk = 1'b0; e.wv = 1'b0; e.wins = NOP; e.wpc = 32'h0;
        tbl.push_back(e);
    endtask

    task automatic setw(input int idx, input bit v, input logic [31:0] ins, pc);
        tbl[idx].wchk = 1'b1;
        tbl[idx].wv   = v;
        tbl[idx].wins = ins;
        tbl[idx].wpc  = pc;
    endtask

    // Reset cycle, then C0..C2 of a clean start from address 0.
    task automatic prologue();
        add(1, 0, 0, 0, 0, 0, 0, NOP, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, NOP, 32'd0, 0);
        add(0, 0, 0, 0, 0, 1, 0, NOP, 32'd8, 0);
        add(0, 0, 0, 0, 0, 1, 1, rom_word(0), 32'd8, 1);
    endtask

    // ---------------- reference model ----------------
    // Per instance: next address to request, the request whose data returns
    // this cycle (address and liveness), and what decode currently sees.
    logic [31:0] m_next[2], m_req[2], m_ins[2], m_pc[2], m_cnt[2];
    logic        m_live[2], m_v[2];

    function automatic logic [31:0] rpc(input int i);
        return (i == 0) ? RPC0 : RPC1;
    endfunction

    task automatic model_edge(input int i, input logic r, s, f, b, input logic [31:0] t);
        if (r) begin
            m_next[i] = rpc(i); m_req[i] = rpc(i); m_live[i] = 1'b0;
            m_v[i] = 1'b0; m_ins[i] = NOP; m_pc[i] = 32'h0; m_cnt[i] = 32'h0;
        end else if (b) begin
            m_next[i] = t & 32'hFFFF_FFFC;
            m_live[i] = 1'b0;
            m_v[i] = 1'b0; m_ins[i] = NOP;
        end else if (s) begin
            if (f) begin
                m_v[i] = 1'b0; m_ins[i] = NOP;
            end
        end else begin
            m_v[i]   = m_live[i] && !f;
            m_ins[i] = m_v[i] ? rom_word(m_req[i]) : NOP;
            m_pc[i]  = m_req[i] + 32'd8;
            if (m_v[i]) m_cnt[i] = m_cnt[i] + 32'd1;
            m_req[i]  = m_next[i];
            m_live[i] = 1'b1;
            m_next[i] = m_next[i] + 32'd4;
        end
    endtask

    function automatic logic [31:0] exp_addr(input int i, input logic r, s, b);
        if (r) return rpc(i);
        if (s && !b) return m_req[i];
        return m_next[i];
    endfunction

    task automatic check_model(input int i, input logic v, input logic [31:0] ins, pc, cnt);
        chk($sformatf("rand%0d valid_D", i), {31'b0, v}, {31'b0, m_v[i]});
        chk($sformatf("rand%0d instr_D", i), ins, m_ins[i]);
        chk($sformatf("rand%0d pc_D", i), pc, m_pc[i]);
        chk($sformatf("rand%0d fetch_count", i), cnt, m_cnt[i]);
    endtask

    initial begin
        int base;
        logic r, s, f, b;
        logic [31:0] t;

        rst = 1'b1; stall_F = 1'b0; flush_D = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0;

        // Reset and straight-line stream; wrap instance checked alongside.
        base = tbl.size();
        prologue();
        add(0, 0, 0, 0, 0, 1, 1, rom_word(4),  32'd12, 2);
        add(0, 0, 0, 0, 0, 1, 1, rom_word(8),  32'd16, 3);
        add(0, 0, 0, 0, 0, 1, 1, rom_word(12), 32'd20, 4);
        setw(base + 1, 0, NOP, 32'h0);
        setw(base + 2, 0, NOP, 32'h0);
        setw(base + 3, 1, rom_word(32'hFFFF_FFF8), 32'h0);
        setw(base + 4, 1, rom_word(32'hFFFF_FFFC), 32'h4);
        setw(base + 5, 1, rom_word(32'h0), 32'h8);
        setw(base + 6, 1, rom_word(32'h4), 32'hC);

        // Taken branch to 0x40 while decode holds B.
        prologue();
        add(0, 0, 0, 1, 32'h40, 1, 1, rom_word(4), 32'd12, 2);
        add(0, 0, 0, 0, 0,      1, 0, NOP, 32'd12, 2);
        add(0, 0, 0, 0, 0,      1, 0, NOP, 32'd16, 2);
        add(0, 0, 0, 0, 0,      1, 1, rom_word(32'h40), 32'h48, 3);
        add(0, 0, 0, 0, 0,      1, 1, rom_word(32'h44), 32'h4C, 4);

        // Three-cycle stall while decode holds B.
        prologue();
        add(0, 1, 0, 0, 0, 1, 1, rom_word(4),  32'd12, 2);
        add(0, 1, 0, 0, 0, 1, 1, rom_word(4),  32'd12, 2);
        add(0, 1, 0, 0, 0, 1, 1, rom_word(4),  32'd12, 2);
        add(0, 0, 0, 0, 0, 1, 1, rom_word(4),  32'd12, 2);
        add(0, 0, 0, 0, 0, 1, 1, rom_word(8),  32'd16, 3);
        add(0, 0, 0, 0, 0, 1, 1, rom_word(12), 32'd20, 4);

        // Stall together with flush, then release.
        prologue();
        add(0, 1, 1, 0, 0, 1, 1, rom_word(4),  32'd12, 2);
        add(0, 0, 0, 0, 0, 1, 0, NOP,          32'd12, 2);
        add(0, 0, 0, 0, 0, 1, 1, rom_word(8),  32'd16, 3);
        add(0, 0, 0, 0, 0, 1, 1, rom_word(12), 32'd20, 4);

        // Branch and stall together (unaligned target), stall kept one more cycle.
        prologue();
        add(0, 1, 0, 1, 32'h83, 1, 1, rom_word(4), 32'd12, 2);
        add(0, 1, 0, 0, 0,      1, 0, NOP, 32'd12, 2);
        add(0, 0, 0, 0, 0,      1, 0, NOP, 32'd12, 2);
        add(0, 0, 0, 0, 0,      1, 0, NOP, 32'd16, 2);
        add(0, 0, 0, 0, 0,      1, 1, rom_word(32'h80), 32'h88, 3);
        add(0, 0, 0, 0, 0,      1, 1, rom_word(32'h84), 32'h8C, 4);

        // One-cycle reset in the middle of the stream.
        prologue();
        add(1, 0, 0, 0, 0, 1, 1, rom_word(4), 32'd12, 2);
        add(0, 0, 0, 0, 0, 1, 0, NOP,         32'd0,  0);
        add(0, 0, 0, 0, 0, 1, 0, NOP,         32'd8,  0);
        add(0, 0, 0, 0, 0, 1, 1, rom_word(0), 32'd8,  1);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            if (tbl[i].chk) begin
                chk($sformatf("vec%0d valid_D", i), {31'b0, valid0}, {31'b0, tbl[i].v});
                chk($sformatf("vec%0d instr_D", i), instr0, tbl[i].ins);
                chk($sformatf("vec%0d pc_D", i), pc0, tbl[i].pc);
                chk($sformatf("vec%0d fetch_count", i), cnt0, tbl[i].cnt);
            end
            if (tbl[i].wchk) begin
                chk($sformatf("vec%0d wrap valid_D", i), {31'b0, valid1}, {31'b0, tbl[i].wv});
                chk($sformatf("vec%0d wrap instr_D", i), instr1, tbl[i].wins);
                chk($sformatf("vec%0d wrap pc_D", i), pc1, tbl[i].wpc);
            end
            rst = tbl[i].rst; stall_F = tbl[i].stall; flush_D = tbl[i].flush;
            branch_taken = tbl[i].br; branch_target = tbl[i].tgt;
            @(posedge clk);
        end

        // Randomized control against the reference model.
        @(negedge clk);
        rst = 1'b1; stall_F = 1'b0; flush_D = 1'b0; branch_taken = 1'b0;
        @(posedge clk);
        model_edge(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        model_edge(1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            check_model(0, valid0, instr0, pc0, cnt0);
            check_model(1, valid1, instr1, pc1, cnt1);

            r = ($urandom_range(0, 99) < 2);
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 6) == 0);
            b = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 2))
                0:       t = $urandom();
                1:       t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: t = 32'($urandom_range(0, 255));
            endcase
            rst = r; stall_F = s; flush_D = f; branch_taken = b; branch_target = t;

            #1;
            chk("rand0 imem_addr", addr0, exp_addr(0, r, s, b));
            chk("rand1 imem_addr", addr1, exp_addr(1, r, s, b));

            @(posedge clk);
            model_edge(0, r, s, f, b, t);
            model_edge(1, r, s, f, b, t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 32-bit pipelined core, directly upstream of the decode stage. It owns the fetch PC, drives a synchronous (1-cycle read latency) instruction ROM, and holds the IF/ID pipeline register that supplies the decode stage with an instruction word, its R15 read value (address + 8) and a valid flag. It handles stall, flush and taken-branch redirect (PCSrc) with a fixed, documented penalty.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.
- `NOP_INSTR`, 32'h0000_0000, word driven on `instr_D` whenever `valid_D` = 0.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall_F`  in  1  hold fetch PC, in-flight request and IF/ID contents.
- `flush_D`  in  1  load a bubble into IF/ID at this edge.
- `branch_taken`  in  1  PCSrc: redirect fetch to `branch_target`.
- `branch_target`  in  32  redirect address; bits [1:0] ignored (forced to 0).
- `imem_addr`  out  32  ROM address; data returns on `imem_rdata` next cycle.
- `imem_rdata`  in  32  ROM data for the address presented in the previous cycle.
- `instr_D`  out  32  instruction to the decode stage.
- `pc_D`  out  32  instruction address + 8 (value decode returns for R15).
- `valid_D`  out  1  `instr_D` is an on-path instruction.
- `fetch_count`  out  32  number of instructions loaded into IF/ID with valid = 1.

## Operation
- State: `fetch_pc` (next address to issue), `resp_pc`/`resp_valid` (request whose data is on `imem_rdata` this cycle), IF/ID {`valid_D`, `instr_D`, `pc_D`}, `fetch_count`.
- Reset (`rst`=1 at edge): `fetch_pc`=`resp_pc`=`RESET_PC`, `resp_valid`=0, `valid_D`=0, `instr_D`=`NOP_INSTR`, `pc_D`=0, `fetch_count`=0. During reset `imem_addr`=`RESET_PC`.
- `imem_addr` is `resp_pc` when `stall_F`=1 and `branch_taken`=0, else `fetch_pc`. This combinational path re-reads the stalled word so `imem_rdata` stays valid with no skid buffer.
- Priority per edge (no reset):
  - **`branch_taken`**: `fetch_pc` ← {`branch_target`[31:2],2'b00}; `resp_valid` ← 0; IF/ID ← bubble. Overrides `stall_F` and `flush_D`.
  - **`stall_F`**: `fetch_pc`, `resp_pc`, `resp_valid` hold. IF/ID holds unless `flush_D`=1, which loads a bubble.
  - **Normal**: IF/ID ← {`resp_valid` & ~`flush_D`, `imem_rdata` or `NOP_INSTR` if invalid, `resp_pc`+8}; `resp_pc` ← `fetch_pc`; `resp_valid` ← 1; `fetch_pc` ← `fetch_pc`+4.
- Bubble means `valid_D`=0, `instr_D`=`NOP_INSTR`, `pc_D` unchanged.
- `fetch_count` increments by 1 on each edge where IF/ID is loaded with valid = 1. It wraps modulo 2^32.
- Arithmetic: all PC sums are 32-bit and wrap modulo 2^32; 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset release: first post-reset cycle C0 presents `RESET_PC`. `instr_D` = mem[`RESET_PC`] with `valid_D`=1 in C2. Fetch-to-decode latency is 2 cycles.
- Steady state: one instruction per cycle, `pc_D` advancing by 4.
- Taken branch asserted in cycle T: `imem_addr`=target in T+1; `valid_D`=0 in T+1 and T+2; target instruction appears in T+3. Branch penalty is 2 bubbles.
- Stall in cycles S..S+n: outputs are frozen throughout. The held instruction is still presented in the first cycle after the stall, and the next sequential instruction follows one cycle later. No instruction is lost or duplicated.
- Simultaneous `branch_taken` and `stall_F`: the branch wins and is never lost.
- `rst` mid-stream discards all in-flight state at that edge.

## Structure
- Shared package `pipe_pkg`: `NOP_INSTR` default, `PC_STEP`=4, `PC_R15_OFFSET`=8, typedef `if_id_t` {valid, instr[31:0], pc8[31:0]}.
- Sub-module `fetch_decode_reg`: the IF/ID register with hold/bubble/load controls and `clk`/`rst`.
- The top level contains the PC logic, the request tracking, the `imem_addr` mux and the counter.

## Test plan
- Reset with ROM[0..3]=A,B,C,D, `RESET_PC`=0, no stalls → C2..C5: `instr_D`=A,B,C,D; `pc_D`=8,12,16,20; `fetch_count`=4 after C5.
- `branch_taken`=1 with target 32'h40 while `instr_D`=B → two cycles of `valid_D`=0 (`instr_D`=`NOP_INSTR`), then ROM[0x40] with `pc_D`=32'h48.
- `stall_F` high for 3 cycles while `instr_D`=B → B held for the 3 cycles, then B once more, then C; `fetch_count` unchanged during the stall.
- `stall_F`=1 and `flush_D`=1 in the same cycle, then release → bubble for one cycle, then the held word follows with none skipped. `branch_taken` and `stall_F` together → the redirect is taken.
- `RESET_PC`=32'hFFFF_FFF8 → addresses wrap to 32'hFFFF_FFFC, then 0, then 4; `pc_D` shows 32'h0000_0000, 32'h0000_0004, 32'h0000_0008.
- Assert `rst` mid-stream for 1 cycle → next cycle `valid_D`=0 and `fetch_count`=0; ROM[`RESET_PC`] appears 2 cycles after release.
